// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo counter and its testbench.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter; master drives controls, slave is the counter.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  import counter_pkg::*;

  logic             en;
  logic             dir;
  cnt_mode_e        mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             at_zero;
  logic             at_max;

  modport master (
    output en, dir, mode, load, load_val, modulus,
    input  count, tc, at_zero, at_max
  );

  modport slave (
    input  en, dir, mode, load, load_val, modulus,
    output count, tc, at_zero, at_max
  );

endinterface

// File: rtl/tick_divider.sv
// Prescaler: counts en-qualified cycles 0..DIV-1 and ticks on the last one; clr restarts the phase.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (clr) begin
      w_cnt_d = '0;
    end else if (en) begin
      w_cnt_d = (r_cnt == Last) ? '0 : r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign tick = en & (r_cnt == Last);

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, wrap/saturate mode and terminal-count pulse.
// Optional prescaler compiled in with CNT_PRESCALE_EN.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  mod_counter_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_d;
  logic             r_tc;
  logic             w_tc_d;
  logic             w_tick;
  logic             w_step;
  logic             w_wrap;

`ifdef CNT_PRESCALE_EN
  tick_divider #(
    .DIV (PRESCALE_DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_step = bus.en & w_tick & ~bus.load;
  assign w_wrap = (bus.mode == CNT_WRAP);

  always_comb begin
    w_count_d = r_count;
    w_tc_d    = 1'b0;
    if (bus.load) begin
      w_count_d = (bus.load_val > bus.modulus) ? bus.modulus : bus.load_val;
    end else if (w_step) begin
      if (r_count > bus.modulus) begin
        // Left out of range by a modulus change: pull back inside.
        if (bus.dir == CNT_UP && w_wrap) begin
          w_count_d = '0;
          w_tc_d    = 1'b1;
        end else begin
          w_count_d = bus.modulus;
        end
      end else if (bus.dir == CNT_UP) begin
        if (r_count == bus.modulus) begin
          if (w_wrap) begin
            w_count_d = '0;
            w_tc_d    = 1'b1;
          end
        end else begin
          w_count_d = r_count + WIDTH'(1);
          w_tc_d    = !w_wrap && (w_count_d == bus.modulus);
        end
      end else begin
        if (r_count == '0) begin
          if (w_wrap) begin
            w_count_d = bus.modulus;
            w_tc_d    = 1'b1;
          end
        end else begin
          w_count_d = r_count - WIDTH'(1);
          w_tc_d    = !w_wrap && (w_count_d == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_tc    <= w_tc_d;
    end
  end

  assign bus.count   = r_count;
  assign bus.tc      = r_tc;
  assign bus.at_zero = (r_count == '0);
  assign bus.at_max  = (r_count == bus.modulus);

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=4); prescaler vectors run with CNT_PRESCALE_EN.
module tb_mod_counter;
  import counter_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  int exp2_cnt[4] = '{1, 0, 5, 4};
  int exp2_tc[4]  = '{0, 0, 1, 0};

  mod_counter_if #(.WIDTH(4)) u_if ();

  mod_counter #(
    .WIDTH        (4),
    .PRESCALE_DIV (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    reset           = 1'b0;
    u_if.en         = 1'b1;
    u_if.dir        = CNT_UP;
    u_if.mode       = CNT_WRAP;
    u_if.load       = 1'b0;
    u_if.load_val   = '0;
    u_if.modulus    = 4'd9;

    // 1: reset held for 10 clocks, then free count 0..9,0 with tc on return to 0
    repeat (10) tick_clk();
    check("rst_count", u_if.count, 0);
    check("rst_tc", u_if.tc, 0);
    check("rst_at_zero", u_if.at_zero, 1);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick_clk();
      check("t1_count", u_if.count, i % 10);
      check("t1_tc", u_if.tc, (i == 10));
      if (i == 9) check("t1_at_max", u_if.at_max, 1);
    end

    // 2: down WRAP, modulus 5, from 2
    u_if.en = 1'b0; u_if.dir = CNT_DOWN; u_if.modulus = 4'd5;
    u_if.load = 1'b1; u_if.load_val = 4'd2;
    tick_clk();
    check("t2_load", u_if.count, 2);
    u_if.load = 1'b0; u_if.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check("t2_count", u_if.count, exp2_cnt[i]);
      check("t2_tc", u_if.tc, exp2_tc[i]);
    end

    // 3: SAT up to 15 then down to 0
    u_if.en = 1'b0; u_if.dir = CNT_UP; u_if.mode = CNT_SAT; u_if.modulus = 4'd15;
    u_if.load = 1'b1; u_if.load_val = 4'd13;
    tick_clk();
    u_if.load = 1'b0; u_if.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      check("t3_up_count", u_if.count, (i == 0) ? 14 : 15);
      check("t3_up_tc", u_if.tc, (i == 1));
    end
    u_if.dir = CNT_DOWN;
    for (int k = 14; k >= 0; k--) begin
      tick_clk();
      check("t3_dn_count", u_if.count, k);
      check("t3_dn_tc", u_if.tc, (k == 0));
    end
    tick_clk();
    check("t3_pin_count", u_if.count, 0);
    check("t3_pin_tc", u_if.tc, 0);

    // 4: load clamps to modulus; then out-of-range recovery
    u_if.mode = CNT_WRAP; u_if.dir = CNT_UP; u_if.modulus = 4'd7;
    u_if.load = 1'b1; u_if.load_val = 4'd12;
    tick_clk();
    check("t4_clamp_count", u_if.count, 7);
    check("t4_clamp_tc", u_if.tc, 0);
    u_if.load = 1'b0; u_if.modulus = 4'd3;
    #1;
    check("t4_oor_at_max", u_if.at_max, 0);
    tick_clk();
    check("t4_oor_up_count", u_if.count, 0);
    check("t4_oor_up_tc", u_if.tc, 1);
    u_if.modulus = 4'd7; u_if.load = 1'b1; u_if.load_val = 4'd7;
    tick_clk();
    u_if.load = 1'b0; u_if.modulus = 4'd3; u_if.dir = CNT_DOWN;
    tick_clk();
    check("t4_oor_dn_count", u_if.count, 3);
    check("t4_oor_dn_tc", u_if.tc, 0);

    // modulus 0: WRAP pulses tc every step, SAT never does
    u_if.modulus = 4'd0; u_if.dir = CNT_UP;
    tick_clk();
    check("m0_wrap_count", u_if.count, 0);
    check("m0_wrap_tc", u_if.tc, 1);
    u_if.dir = CNT_DOWN;
    tick_clk();
    check("m0_wrap_dn_tc", u_if.tc, 1);
    u_if.mode = CNT_SAT;
    tick_clk();
    check("m0_sat_count", u_if.count, 0);
    check("m0_sat_tc", u_if.tc, 0);

    // 5: async reset between edges at count 6
    u_if.mode = CNT_WRAP; u_if.dir = CNT_UP; u_if.modulus = 4'd9;
    u_if.load = 1'b1; u_if.load_val = 4'd0;
    tick_clk();
    u_if.load = 1'b0;
    repeat (6) tick_clk();
    check("t5_pre_count", u_if.count, 6);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_count", u_if.count, 0);
    check("t5_rst_tc", u_if.tc, 0);
    tick_clk();
    reset = 1'b1;
    tick_clk();
    check("t5_resume_count", u_if.count, 1);

`ifdef CNT_PRESCALE_EN
    // 6: divide-by-4 steps, en gap stretches interval, load resets phase
    u_if.modulus = 4'd15; u_if.load = 1'b1; u_if.load_val = 4'd0;
    tick_clk();
    u_if.load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick_clk();
      check("t6_count", u_if.count, i / 4);
    end
    u_if.en = 1'b0;
    repeat (3) tick_clk();
    check("t6_gap_count", u_if.count, 2);
    u_if.en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick_clk();
      check("t6_after_gap", u_if.count, (i == 4) ? 3 : 2);
    end
    tick_clk();
    u_if.load = 1'b1; u_if.load_val = 4'd5;
    tick_clk();
    u_if.load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick_clk();
      check("t6_phase", u_if.count, (i == 4) ? 6 : 5);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
